// File: rtl/rmt_alu_pkg.sv
// Shared opcode map, container geometry and action-slot bit offsets for the RMT ALU stage.
// Consumers: alu_4b_lane (ALU_SATURATE_EN selects clamping) and alu_stage_4b.
package rmt_alu_pkg;

    localparam int WIDTH_4B = 32;
    localparam int TAIL_W   = 256;

    // Opcode field position inside one ACT_LEN-wide action slot
    localparam int OPC_HI = 63;
    localparam int OPC_W  = 8;

    localparam logic [OPC_W-1:0] OP_ADD   = 8'h01;
    localparam logic [OPC_W-1:0] OP_SUB   = 8'h02;
    localparam logic [OPC_W-1:0] OP_LOADD = 8'h07;
    localparam logic [OPC_W-1:0] OP_STORE = 8'h08;
    localparam logic [OPC_W-1:0] OP_ADDI  = 8'h09;
    localparam logic [OPC_W-1:0] OP_SUBI  = 8'h0A;
    localparam logic [OPC_W-1:0] OP_LOAD  = 8'h0B;
    localparam logic [OPC_W-1:0] OP_SET   = 8'h0E;

endpackage

// File: rtl/alu_4b_lane.sv
// Combinational single-container ALU: ADD/SUB/ADDI/SUBI/SET, everything else passes the original.
// Define ALU_SATURATE_EN to clamp on carry/borrow instead of wrapping.
module alu_4b_lane
    import rmt_alu_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [OPC_W-1:0] i_opcode,
    input  logic [W-1:0]     i_a,
    input  logic [W-1:0]     i_b,
    input  logic [W-1:0]     i_orig,
    output logic [W-1:0]     o_result
);

    function automatic logic [W-1:0] f_add(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef ALU_SATURATE_EN
        logic [W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[W] ? {W{1'b1}} : s[W-1:0];
`else
        return a + b;
`endif
    endfunction

    function automatic logic [W-1:0] f_sub(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef ALU_SATURATE_EN
        logic [W:0] d;
        d = {1'b0, a} - {1'b0, b};
        return d[W] ? {W{1'b0}} : d[W-1:0];
`else
        return a - b;
`endif
    endfunction

    // Stateful opcodes (LOAD/STORE/LOADD) are executed elsewhere; here they pass through
    always_comb begin
        o_result = i_orig;
        case (i_opcode)
            OP_ADD, OP_ADDI: o_result = f_add(i_a, i_b);
            OP_SUB, OP_SUBI: o_result = f_sub(i_a, i_b);
            OP_SET:          o_result = i_b;
            default:         o_result = i_orig;
        endcase
    end

endmodule

// File: rtl/alu_stage_4b.sv
// RMT 4-byte ALU stage: per-container stateless ops, PHV reassembly, 3-entry output buffer.
// ALU_SATURATE_EN (see alu_4b_lane) switches arithmetic from wrap to saturate.
module alu_stage_4b
    import rmt_alu_pkg::*;
#(
    parameter int STAGE_ID  = 0,
    parameter int NUM_CONT  = 64,
    parameter int WIDTH_4B  = 32,
    parameter int ACT_LEN   = 64,
    parameter int ACT_SLOTS = 193,
    parameter int PHV_LEN   = NUM_CONT*WIDTH_4B+256
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          alu_in_valid,
    input  logic [NUM_CONT*WIDTH_4B-1:0]  alu_in_4B_1,
    input  logic [NUM_CONT*WIDTH_4B-1:0]  alu_in_4B_2,
    input  logic [NUM_CONT*WIDTH_4B-1:0]  alu_in_4B_3,
    input  logic [TAIL_W-1:0]             phv_remain_data,
    input  logic [ACT_LEN*ACT_SLOTS-1:0]  action_in,
    input  logic                          action_valid_in,
    output logic                          ready_out,
    output logic [PHV_LEN-1:0]            phv_out,
    output logic                          phv_out_valid,
    input  logic                          ready_in,
    output logic                          overflow_err
);

    localparam int ACT_W  = ACT_LEN*ACT_SLOTS;
    localparam int CONT_W = NUM_CONT*WIDTH_4B;

    logic [CONT_W-1:0]  w_result;
    logic [PHV_LEN-1:0] w_phv_new;

    // Container i takes its opcode from slot i+1; slot 0 is counted from the MSB
    for (genvar g = 0; g < NUM_CONT; g++) begin : g_lane
        logic [OPC_W-1:0] w_op;
        if (g == 0) begin : g_reserved
            assign w_op = '0;
        end else begin : g_alu
            assign w_op = action_valid_in
                ? action_in[ACT_W-1-(g+1)*ACT_LEN-(ACT_LEN-1-OPC_HI) -: OPC_W]
                : '0;
        end
        alu_4b_lane #(.W(WIDTH_4B)) u_lane (
            .i_opcode (w_op),
            .i_a      (alu_in_4B_1[g*WIDTH_4B +: WIDTH_4B]),
            .i_b      (alu_in_4B_2[g*WIDTH_4B +: WIDTH_4B]),
            .i_orig   (alu_in_4B_3[g*WIDTH_4B +: WIDTH_4B]),
            .o_result (w_result[g*WIDTH_4B +: WIDTH_4B])
        );
    end

    assign w_phv_new = {w_result, phv_remain_data};

    // ---- output buffer ----
    logic [PHV_LEN-1:0] r_mem [3];
    logic [1:0]         r_wr;
    logic [1:0]         r_rd;
    logic [1:0]         r_cnt;
    logic               r_ready;
    logic               r_ovf;
    logic               w_pop;
    logic               w_push;
    logic [1:0]         w_cnt_nxt;

    // A pop frees the head slot first, so a full buffer can still take a beat
    always_comb begin
        w_pop     = (r_cnt != 2'd0) && ready_in;
        w_push    = alu_in_valid && ((r_cnt != 2'd3) || w_pop);
        w_cnt_nxt = r_cnt + 2'(w_push) - 2'(w_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr    <= 2'd0;
            r_rd    <= 2'd0;
            r_cnt   <= 2'd0;
            r_ready <= 1'b1;
            r_ovf   <= 1'b0;
        end else begin
            if (w_push) r_wr <= (r_wr == 2'd2) ? 2'd0 : r_wr + 2'd1;
            if (w_pop)  r_rd <= (r_rd == 2'd2) ? 2'd0 : r_rd + 2'd1;
            r_cnt   <= w_cnt_nxt;
            r_ready <= (w_cnt_nxt <= 2'd1);
            if (alu_in_valid && !w_push) r_ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= w_phv_new;
    end

    assign phv_out       = (r_cnt != 2'd0) ? r_mem[r_rd] : '0;
    assign phv_out_valid = (r_cnt != 2'd0);
    assign ready_out     = r_ready;
    assign overflow_err  = r_ovf;

endmodule

// File: doc/alu_stage_4b.md
# alu_stage_4b

Per-container 4-byte ALU stage of an RMT match-action pipeline. It sits directly downstream of the action crossbar and consumes the three operand vectors, the untouched 256-bit PHV tail and the one-cycle-aligned action word. It executes one stateless op per 32-bit container, reassembles the PHV and hands it to the next stage through a 3-entry output buffer. The buffer absorbs the in-flight beat that a registered-ready upstream can still launch.

## Interface
Parameters:
- `STAGE_ID`, 0, stage index; informational only.
- `NUM_CONT`, 64, number of 4B containers.
- `WIDTH_4B`, 32, container width.
- `ACT_LEN`, 64, bits per action slot.
- `ACT_SLOTS`, 193, slots in the action word.
- `PHV_LEN`, NUM_CONT*WIDTH_4B+256, output PHV width.

Ports:
- `clk`  in  1  sole clock.
- `rst`  in  1  synchronous, active-high reset.
- `alu_in_valid`  in  1  operand beat valid.
- `alu_in_4B_1`  in  NUM_CONT*WIDTH_4B  operand A, container i at bits [(i+1)*32-1 -: 32].
- `alu_in_4B_2`  in  NUM_CONT*WIDTH_4B  operand B (container or immediate).
- `alu_in_4B_3`  in  NUM_CONT*WIDTH_4B  original container value.
- `phv_remain_data`  in  256  metadata/conditional tail.
- `action_in`  in  ACT_LEN*ACT_SLOTS  action word, aligned with the operands.
- `action_valid_in`  in  1  action word valid; sampled together with `alu_in_valid`.
- `ready_out`  out  1  registered; upstream may send while it is high.
- `phv_out`  out  PHV_LEN  {result[63], …, result[0], remain}.
- `phv_out_valid`  out  1  head entry valid.
- `ready_in`  in  1  downstream accepts when high together with valid.
- `overflow_err`  out  1  sticky; set when a beat arrives while the buffer is full.

## Operation
- Slots are numbered from the MSB: slot s = action_in[ACT_LEN*ACT_SLOTS-1-s*ACT_LEN -: ACT_LEN]. Container i uses the opcode in slot i+1, bits [63:56].
- Opcodes:
  - 0x01 ADD: A+B.
  - 0x02 SUB: A−B.
  - 0x09 ADDI: A+B.
  - 0x0A SUBI: A−B.
  - 0x0E SET: B.
  - 0x07, 0x08, 0x0B (stateful, handled elsewhere): result = original container (operand 3).
  - Any other opcode: result = operand 3.
- Container 0 is reserved: result is always operand 3.
- Arithmetic is 32-bit unsigned and wraps modulo 2^32 unless saturation is compiled in.
- Push condition: `alu_in_valid` high. `action_valid_in` low with `alu_in_valid` high makes every container act as no-op (pass-through).
- Output buffer:
  - 3-entry FIFO holding the full PHV_LEN result.
  - Head drives `phv_out`; `phv_out_valid` = occupancy ≠ 0.
  - Pop on `phv_out_valid & ready_in`.
- Push and pop in the same cycle: occupancy unchanged; allowed when full (pop frees the slot first).
- Push when full without a pop: the beat is dropped, `overflow_err` is set, and FIFO contents are unchanged.
- `ready_out` <= (next occupancy ≤ 1).

## Timing
- Reset values: `ready_out`=1, `phv_out_valid`=0, `phv_out`=0, `overflow_err`=0, occupancy=0, pointers=0.
- Reset mid-operation discards all buffered beats; the first post-reset cycle accepts input.
- Latency: a beat pushed at edge N is visible on `phv_out` with `phv_out_valid`=1 after edge N (one cycle), if the FIFO was empty.
- Throughput: 1 beat/cycle while `ready_in` is held high.
- `ready_out` falls in the cycle after occupancy reaches 2. It rises in the cycle after occupancy drops to ≤1.
- One additional beat arriving after `ready_out` falls is absorbed by entry 3.
- `phv_out` is stable while `phv_out_valid & ~ready_in`.
- Pointers wrap 2→0.
- `overflow_err` clears only on `rst`.

## Configuration
- `ALU_SATURATE_EN` defined:
  - ADD/ADDI clamp to 0xFFFF_FFFF on carry-out.
  - SUB/SUBI clamp to 0 on borrow.
- Not defined: plain modulo-2^32 wrap.
- SET and pass-through are unaffected in both cases.

## Structure
- Package `rmt_alu_pkg`:
  - Opcode localparams (OP_ADD, OP_SUB, OP_ADDI, OP_SUBI, OP_SET, OP_LOAD, OP_STORE, OP_LOADD).
  - WIDTH_4B, the 256-bit tail width, and the slot→opcode bit offsets.
- Sub-module `alu_4b_lane`: combinational; inputs opcode, A, B, original; output result; contains the saturation ifdef.
  - Instantiated NUM_CONT times by generate.
  - Lane 0 is tied to pass-through.
- FIFO pointers, occupancy counter and ready register stay inline in `alu_stage_4b`.

## Test plan
- Lane 5, opcode 0x01, A=0x0000_0010, B=0x0000_0005, ready_in=1 → one cycle later container 5 = 0x0000_0015; all other containers equal operand 3; tail equals input.
- Lane 7 SUBI, A=3, B=5 → wrap build 0xFFFF_FFFE; ALU_SATURATE_EN build 0. Lane 7 ADD 0xFFFF_FFFF+2 → 0x0000_0001 (wrap) or 0xFFFF_FFFF (saturate).
- Lane 9 SET, B=0xDEAD_BEEF → 0xDEAD_BEEF. Lane 9 opcode 0x0B or 0x55 → operand 3 value. Lane 0 with ADD → operand 3 value.
- ready_in=0, send 3 consecutive beats → ready_out drops after beat 2; all 3 buffered; overflow_err=0. A 4th beat → dropped, overflow_err=1. Then ready_in=1 → beats 1,2,3 emerge in order on consecutive cycles.
- Full FIFO with simultaneous push and pop → occupancy stays 3, no error, order preserved.
- rst asserted with 2 beats buffered → next cycle phv_out_valid=0, ready_out=1, overflow_err=0.
